// File: rtl/noobs_dmem_responder.sv
// Data-memory slave for noobs_cpu: byte RAM below MMIO_BASE, plus a small MMIO window
// holding a 16-bit cycle timer and a debug-console TX FIFO drained over valid/ready.
module noobs_dmem_responder #(
  parameter int unsigned            ADDR_W     = 12,
  parameter logic [ADDR_W-1:0]      MMIO_BASE  = 12'hFF0,
  parameter int unsigned            FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m_en,
  input  logic              i_m_rd,
  input  logic              i_m_wr,
  input  logic [ADDR_W-1:0] i_m_addr,
  input  logic [7:0]        i_m_wr_data,
  output logic [7:0]        o_m_rd_data,
  output logic [7:0]        o_con_data,
  output logic              o_con_valid,
  input  logic              i_con_ready,
  output logic              o_err
);

  localparam int unsigned RamDepth = int'(MMIO_BASE);
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  FullCnt  = 4'(FIFO_DEPTH);

  logic [7:0]        r_mem [RamDepth];
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [3:0]        r_count;
  logic [15:0]       r_timer;
  logic [7:0]        r_shadow;
  logic              r_tmr_en;
  logic              r_err, r_ovf;
  logic [7:0]        r_rd_data;

  logic              w_rd_req, w_wr_req, w_bad;
  logic              w_is_mmio;
  logic [ADDR_W-1:0] w_off;
  logic              w_sel_lo, w_sel_hi, w_sel_ctrl, w_sel_con, w_sel_stat;
  logic              w_full, w_empty, w_pop, w_push_req, w_push, w_ovf_set;
  logic              w_tmr_clr;
  logic [7:0]        w_status, w_rd_val;

  assign w_rd_req  = i_m_en & i_m_rd & ~i_m_wr;
  assign w_wr_req  = i_m_en & i_m_wr & ~i_m_rd;
  assign w_bad     = i_m_en & i_m_rd & i_m_wr;

  assign w_is_mmio  = (i_m_addr >= MMIO_BASE);
  assign w_off      = i_m_addr - MMIO_BASE;
  assign w_sel_lo   = w_is_mmio & (w_off == ADDR_W'(0));
  assign w_sel_hi   = w_is_mmio & (w_off == ADDR_W'(1));
  assign w_sel_ctrl = w_is_mmio & (w_off == ADDR_W'(2));
  assign w_sel_con  = w_is_mmio & (w_off == ADDR_W'(3));
  assign w_sel_stat = w_is_mmio & (w_off == ADDR_W'(4));

  assign w_full     = (r_count == FullCnt);
  assign w_empty    = (r_count == 4'd0);
  assign w_pop      = ~w_empty & i_con_ready;
  assign w_push_req = w_wr_req & w_sel_con;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_tmr_clr  = w_wr_req & w_sel_ctrl & i_m_wr_data[1];

  assign w_status   = {r_ovf, r_err, w_full, w_empty, r_count};

  assign o_m_rd_data = r_rd_data;
  assign o_con_valid = ~w_empty;
  assign o_con_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign o_err       = r_err;

  // Read-data mux over RAM and the MMIO registers; unmapped offsets read zero.
  always_comb begin
    w_rd_val = 8'h00;
    if (!w_is_mmio)      w_rd_val = r_mem[i_m_addr];
    else if (w_sel_lo)   w_rd_val = r_timer[7:0];
    else if (w_sel_hi)   w_rd_val = r_shadow;
    else if (w_sel_ctrl) w_rd_val = {7'b0, r_tmr_en};
    else if (w_sel_stat) w_rd_val = w_status;
  end

  // RAM write port; contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_req && !w_is_mmio) r_mem[i_m_addr] <= i_m_wr_data;
  end

  // Registered read data; illegal and idle cycles hold the last value.
  always_ff @(posedge i_clk) begin
    if (i_reset)       r_rd_data <= 8'h00;
    else if (w_rd_req) r_rd_data <= w_rd_val;
  end

  // Timer, enable and high-byte shadow captured by a TMR_LO read.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer  <= 16'h0000;
      r_tmr_en <= 1'b0;
      r_shadow <= 8'h00;
    end else begin
      if (w_tmr_clr)     r_timer <= 16'h0000;
      else if (r_tmr_en) r_timer <= r_timer + 16'd1;
      if (w_wr_req && w_sel_ctrl) r_tmr_en <= i_m_wr_data[0];
      if (w_rd_req && w_sel_lo)   r_shadow <= r_timer[15:8];
    end
  end

  // Sticky error and overflow flags; a set event wins over a simultaneous W1C.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_bad)                                         r_err <= 1'b1;
      else if (w_wr_req && w_sel_stat && i_m_wr_data[6]) r_err <= 1'b0;
      if (w_ovf_set)                                     r_ovf <= 1'b1;
      else if (w_wr_req && w_sel_stat && i_m_wr_data[7]) r_ovf <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 4'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + 4'd1;
      else if (w_pop && !w_push) r_count <= r_count - 4'd1;
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr] <= i_m_wr_data;
  end

endmodule

// File: tb/tb_noobs_dmem_responder.sv
// Bench for noobs_dmem_responder: directed scenarios with literal expectations, then a
// randomized phase checked every cycle against a behavioural model (array RAM, queue FIFO).
module tb_noobs_dmem_responder;
  localparam logic [11:0] Base  = 12'hFF0;
  localparam logic [11:0] ALo   = Base + 12'd0;
  localparam logic [11:0] AHi   = Base + 12'd1;
  localparam logic [11:0] ACtrl = Base + 12'd2;
  localparam logic [11:0] ACon  = Base + 12'd3;
  localparam logic [11:0] AStat = Base + 12'd4;
  localparam int Depth = 8;

  logic        clk = 1'b0;
  logic        rst, en, rd, wr, cready;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata, cdata;
  logic        cvalid, err;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [7:0]  m_ram [4096];
  byte unsigned q[$];
  logic [15:0] m_timer;
  logic        m_tmr_en, m_err, m_ovf;
  logic [7:0]  m_shadow, m_rd;

  noobs_dmem_responder #(
    .ADDR_W    (12),
    .MMIO_BASE (12'hFF0),
    .FIFO_DEPTH(8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_m_en     (en),
    .i_m_rd     (rd),
    .i_m_wr     (wr),
    .i_m_addr   (addr),
    .i_m_wr_data(wdata),
    .o_m_rd_data(rdata),
    .o_con_data (cdata),
    .o_con_valid(cvalid),
    .i_con_ready(cready),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovf, m_err, q.size() == Depth, q.size() == 0, 4'(q.size())};
  endfunction

  // Apply the rules for one accepting clock edge to the model.
  task automatic model_update();
    logic        r, w, bad, mm, full, pop;
    logic [11:0] off;
    logic [15:0] nt;
    if (rst) begin
      m_rd = 8'h00; q.delete(); m_timer = 16'h0; m_tmr_en = 1'b0;
      m_shadow = 8'h00; m_err = 1'b0; m_ovf = 1'b0;
      return;
    end
    r    = en & rd & ~wr;
    w    = en & wr & ~rd;
    bad  = en & rd & wr;
    mm   = (addr >= Base);
    off  = addr - Base;
    full = (q.size() == Depth);
    pop  = (q.size() != 0) && cready;
    nt   = m_tmr_en ? m_timer + 16'd1 : m_timer;
    if (r) begin
      if (!mm)            m_rd = m_ram[addr];
      else if (off == 0) begin m_rd = m_timer[7:0]; m_shadow = m_timer[15:8]; end
      else if (off == 1)  m_rd = m_shadow;
      else if (off == 2)  m_rd = {7'b0, m_tmr_en};
      else if (off == 4)  m_rd = m_status();
      else                m_rd = 8'h00;
    end
    if (pop) void'(q.pop_front());
    if (w) begin
      if (!mm) m_ram[addr] = wdata;
      else if (off == 2) begin
        m_tmr_en = wdata[0];
        if (wdata[1]) nt = 16'h0;
      end else if (off == 3) begin
        if (!full || pop) q.push_back(wdata);
        else              m_ovf = 1'b1;
      end else if (off == 4) begin
        if (wdata[7]) m_ovf = 1'b0;
        if (wdata[6]) m_err = 1'b0;
      end
    end
    if (bad) m_err = 1'b1;
    m_timer = nt;
  endtask

  task automatic compare();
    chk("rd_data", {8'h0, rdata}, {8'h0, m_rd});
    chk("con_valid", {15'h0, cvalid}, {15'h0, q.size() != 0});
    chk("con_data", {8'h0, cdata}, {8'h0, (q.size() != 0) ? 8'(q[0]) : 8'h00});
    chk("err", {15'h0, err}, {15'h0, m_err});
  endtask

  // One clock: model steps at the edge, DUT outputs are compared half a cycle later.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    en = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_wr(input logic [11:0] a, input logic [7:0] d);
    en = 1'b1; rd = 1'b0; wr = 1'b1; addr = a; wdata = d;
    step();
    idle();
  endtask

  task automatic do_rd(input logic [11:0] a);
    en = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    step();
    idle();
  endtask

  initial begin
    logic [7:0]  lo, hi, hi_before;
    logic [15:0] tv;
    int          guard;
    rst = 1'b1; en = 1'b0; rd = 1'b0; wr = 1'b0; cready = 1'b0;
    addr = 12'h0; wdata = 8'h0;
    for (int i = 0; i < 4096; i++) m_ram[i] = 8'h00;
    step();
    step();
    chk("reset_rd_data", {8'h0, rdata}, 16'h0000);
    chk("reset_con_valid", {15'h0, cvalid}, 16'h0000);
    chk("reset_err", {15'h0, err}, 16'h0000);
    rst = 1'b0;

    // 1: RAM write then read
    do_wr(12'h010, 8'h5A);
    do_rd(12'h010);
    chk("ram_rd_5a", {8'h0, rdata}, 16'h005A);

    // 2: timer enable, 300 cycles, coherent read
    do_wr(ACtrl, 8'h01);
    for (int i = 0; i < 300; i++) step();
    do_rd(ALo); lo = rdata;
    do_rd(AHi); hi = rdata;
    tv = {hi, lo};
    chk("tmr_300", {15'h0, (tv >= 16'd298) && (tv <= 16'd302)}, 16'h0001);
    chk("tmr_exact", tv, 16'd300);
    guard = 0;
    while (m_timer[7:0] != 8'hFF && guard < 600) begin step(); guard++; end
    chk("tmr_wrap_reached", {15'h0, guard < 600}, 16'h0001);
    hi_before = m_timer[15:8];
    do_rd(ALo); lo = rdata;
    do_rd(AHi); hi = rdata;
    chk("tmr_lo_ff", {8'h0, lo}, 16'h00FF);
    chk("tmr_no_tear", {8'h0, hi}, {8'h0, hi_before});

    // 3: overflow a stalled FIFO, then drain in order
    cready = 1'b0;
    for (int i = 1; i <= 9; i++) do_wr(ACon, 8'(i));
    do_rd(AStat);
    chk("status_a8", {8'h0, rdata}, 16'h00A8);
    cready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain", {8'h0, cdata}, 16'(i));
      step();
    end
    chk("drained_valid", {15'h0, cvalid}, 16'h0000);
    cready = 1'b0;
    do_wr(AStat, 8'h80);

    // 4: push into a full FIFO while the head pops
    for (int i = 0; i < 8; i++) do_wr(ACon, 8'h11 + 8'(i));
    cready = 1'b1;
    do_wr(ACon, 8'h99);
    cready = 1'b0;
    do_rd(AStat);
    chk("status_28", {8'h0, rdata}, 16'h0028);
    cready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain2", {8'h0, cdata}, (i == 7) ? 16'h0099 : 16'h0012 + 16'(i));
      step();
    end
    cready = 1'b0;

    // 5: illegal simultaneous read+write
    do_rd(12'h010);
    en = 1'b1; rd = 1'b1; wr = 1'b1; addr = 12'h010; wdata = 8'h77;
    step();
    idle();
    chk("bad_err", {15'h0, err}, 16'h0001);
    chk("bad_rd_hold", {8'h0, rdata}, 16'h005A);
    do_rd(12'h010);
    chk("bad_ram_kept", {8'h0, rdata}, 16'h005A);
    do_wr(AStat, 8'h40);
    chk("err_cleared", {15'h0, err}, 16'h0000);

    // 6: reset mid-operation
    do_wr(ACtrl, 8'h01);
    for (int i = 0; i < 3; i++) do_wr(ACon, 8'hC0 + 8'(i));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_con_valid", {15'h0, cvalid}, 16'h0000);
    chk("rst_rd_data", {8'h0, rdata}, 16'h0000);
    for (int i = 0; i < 5; i++) step();
    do_rd(ALo);
    chk("rst_tmr_lo", {8'h0, rdata}, 16'h0000);
    do_rd(12'h010);
    chk("rst_ram_kept", {8'h0, rdata}, 16'h005A);

    // Randomized phase over pre-initialised RAM and the whole MMIO window
    for (int i = 0; i < 32; i++) do_wr(12'(i), 8'($urandom));
    for (int n = 0; n < 3000; n++) begin
      int unsigned kind;
      kind   = $urandom_range(0, 99);
      cready = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      wdata  = 8'($urandom);
      en = 1'b1; rd = 1'b0; wr = 1'b0;
      if (kind < 10) begin
        en = 1'b0; rd = 1'($urandom); wr = 1'($urandom);
        addr = 12'($urandom);
      end else if (kind < 25) begin
        wr = 1'b1; addr = 12'($urandom_range(0, 31));
      end else if (kind < 45) begin
        rd = 1'b1; addr = 12'($urandom_range(0, 31));
      end else if (kind < 65) begin
        rd = 1'b1; addr = Base + 12'($urandom_range(0, 15));
      end else if (kind < 85) begin
        wr = 1'b1; addr = ACon;
      end else if (kind < 90) begin
        wr = 1'b1; addr = AStat;
      end else if (kind < 94) begin
        wr = 1'b1; addr = ACtrl;
      end else if (kind < 97) begin
        wr = 1'b1; addr = Base + 12'($urandom_range(5, 15));
      end else begin
        rd = 1'b1; wr = 1'b1; addr = 12'($urandom_range(0, 31));
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
